// File: rtl/keypad_timebase_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_timebase_pkg
//  Purpose  : Shared definitions for the keypad front end and timebase:
//             key FSM state encoding, a constant clog2 helper and the
//             default parameter values.
//  Revision : 1.0  initial release
// ============================================================================
package keypad_timebase_pkg;

    localparam int c_NUM_KEYS_DEFAULT     = 10;
    localparam int c_CODE_W_DEFAULT       = 4;
    localparam int c_DEBOUNCE_CYC_DEFAULT = 4;
    localparam int c_CLK_DIV_DEFAULT      = 100;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        DEBOUNCE = 2'd1,
        HELD     = 2'd2,
        RELEASE  = 2'd3
    } key_state_t;

    // Ceiling log2, usable in constant expressions (register widths).
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage
`default_nettype wire

// File: rtl/keypad_timebase_tick_divider.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_timebase_tick_divider
//  Purpose  : Periodic tick generator. While run is high, emits a one-cycle
//             tick after every CLK_DIV consecutive running edges. Dropping
//             run discards the partial count.
//  Ports    : clk   - system clock
//             reset - synchronous active-high reset
//             run   - 1 = count, 0 = hold count at zero
//             tick  - registered one-cycle pulse
//  Revision : 1.0  initial release
// ============================================================================
module keypad_timebase_tick_divider
    import keypad_timebase_pkg::*;
#(
    parameter int CLK_DIV = c_CLK_DIV_DEFAULT
) (
    input  logic clk,
    input  logic reset,
    input  logic run,
    output logic tick
);

    localparam int               c_CNT_W = clog2(CLK_DIV + 1);
    localparam logic [c_CNT_W-1:0] c_LAST = c_CNT_W'(CLK_DIV - 1);

    logic [c_CNT_W-1:0] r_count;
    logic               r_tick;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (!run) begin
            r_count <= '0;
            r_tick  <= 1'b0;
        end else if (r_count == c_LAST) begin
            // With CLK_DIV=1 this branch is taken every edge: tick stays high.
            r_count <= '0;
            r_tick  <= 1'b1;
        end else begin
            r_count <= r_count + 1'b1;
            r_tick  <= 1'b0;
        end
    end

    assign tick = r_tick;

endmodule
`default_nettype wire

// File: rtl/keypad_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : keypad_timebase
//  Purpose  : Keypad front end and countdown timebase for the microwave
//             controller. Synchronises and debounces a one-hot keypad,
//             encodes the accepted key, and generates the countdown tick
//             while the timer runs.
//  Ports    : clk       - system clock
//             reset     - synchronous active-high reset
//             keyboard  - raw asynchronous key lines, 1 = pressed
//             enablen   - 0 = timer running (keys ignored), 1 = entry mode
//             key_code  - binary index of the last accepted key
//             key_valid - one-cycle strobe on a newly accepted key
//             loadn     - low while the accepted key is held
//             multi_key - high while the candidate sample has >1 key set
//             p_tick    - one-cycle pulse every CLK_DIV running cycles
//  Revision : 1.0  initial release
// ============================================================================
module keypad_timebase
    import keypad_timebase_pkg::*;
#(
    parameter int NUM_KEYS     = c_NUM_KEYS_DEFAULT,
    parameter int CODE_W       = c_CODE_W_DEFAULT,
    parameter int DEBOUNCE_CYC = c_DEBOUNCE_CYC_DEFAULT,
    parameter int CLK_DIV      = c_CLK_DIV_DEFAULT
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NUM_KEYS-1:0] keyboard,
    input  logic                enablen,
    output logic [CODE_W-1:0]   key_code,
    output logic                key_valid,
    output logic                loadn,
    output logic                multi_key,
    output logic                p_tick
);

    localparam int                 c_CNT_W = clog2(DEBOUNCE_CYC + 1);
    localparam logic [c_CNT_W-1:0] c_DEB   = c_CNT_W'(DEBOUNCE_CYC);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [NUM_KEYS-1:0] r_sync1;
    logic [NUM_KEYS-1:0] r_sync2;
    logic [NUM_KEYS-1:0] r_cand;
    logic [c_CNT_W-1:0]  r_cnt;
    key_state_t          r_state;
    logic [CODE_W-1:0]   r_key_code;
    logic                r_key_valid;
    logic                r_loadn;
    logic                r_multi_key;

    logic                w_s_any;
    logic                w_s_multi;

    // Lowest set index wins when several keys are down.
    function automatic logic [CODE_W-1:0] lowest_index(input logic [NUM_KEYS-1:0] v);
        logic [CODE_W-1:0] r;
        r = '0;
        for (int i = NUM_KEYS - 1; i >= 0; i--) begin
            if (v[i]) begin
                r = CODE_W'(i);
            end
        end
        return r;
    endfunction

    assign w_s_any   = |r_sync2;
    // Clearing the lowest set bit leaves something only if >1 bit was set.
    assign w_s_multi = |(r_sync2 & (r_sync2 - NUM_KEYS'(1)));

    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1     <= '0;
            r_sync2     <= '0;
            r_cand      <= '0;
            r_cnt       <= '0;
            r_state     <= IDLE;
            r_key_code  <= '0;
            r_key_valid <= 1'b0;
            r_loadn     <= 1'b1;
            r_multi_key <= 1'b0;
        end else begin
            r_sync1     <= keyboard;
            r_sync2     <= r_sync1;
            r_key_valid <= 1'b0;

            if (!enablen) begin
                // Timer running: keypad is ignored, key_code keeps its value.
                r_state     <= IDLE;
                r_cnt       <= '0;
                r_loadn     <= 1'b1;
                r_multi_key <= 1'b0;
            end else begin
                case (r_state)
                    IDLE: begin
                        r_loadn     <= 1'b1;
                        r_multi_key <= 1'b0;
                        if (w_s_any) begin
                            r_state     <= DEBOUNCE;
                            r_cand      <= r_sync2;
                            r_cnt       <= c_ONE;
                            r_multi_key <= w_s_multi;
                        end
                    end
                    DEBOUNCE: begin
                        if (!w_s_any) begin
                            r_state     <= IDLE;
                            r_multi_key <= 1'b0;
                        end else if (r_sync2 != r_cand) begin
                            r_cand      <= r_sync2;
                            r_cnt       <= c_ONE;
                            r_multi_key <= w_s_multi;
                        end else if (r_cnt == c_DEB) begin
                            // Enough matching samples: accept the key.
                            r_state     <= HELD;
                            r_key_valid <= 1'b1;
                            r_key_code  <= lowest_index(r_cand);
                            r_loadn     <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    HELD: begin
                        // Changes to which keys are down are ignored until release.
                        if (!w_s_any) begin
                            r_state <= RELEASE;
                            r_cnt   <= c_ONE;
                        end
                    end
                    RELEASE: begin
                        if (w_s_any) begin
                            // Release glitch: resume holding without a new strobe.
                            r_state <= HELD;
                        end else if (r_cnt == c_DEB) begin
                            r_state     <= IDLE;
                            r_loadn     <= 1'b1;
                            r_multi_key <= 1'b0;
                        end else begin
                            r_cnt <= r_cnt + 1'b1;
                        end
                    end
                    default: begin
                        r_state <= IDLE;
                    end
                endcase
            end
        end
    end

    keypad_timebase_tick_divider #(
        .CLK_DIV (CLK_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .reset (reset),
        .run   (~enablen),
        .tick  (p_tick)
    );

    assign key_code  = r_key_code;
    assign key_valid = r_key_valid;
    assign loadn     = r_loadn;
    assign multi_key = r_multi_key;

endmodule
`default_nettype wire

// File: tb/tb_keypad_timebase.sv
`default_nettype none
// ============================================================================
//  Module   : tb_keypad_timebase
//  Purpose  : Self-checking bench for keypad_timebase. Expected key strobes
//             and ticks are queued when stimulus is applied and matched
//             against the DUT outputs as they appear.
//  Revision : 1.0  initial release
// ============================================================================
module tb_keypad_timebase;

    localparam int NUM_KEYS = 10;
    localparam int CODE_W   = 4;

    logic                clk;
    logic                reset;
    logic [NUM_KEYS-1:0] keyboard;
    logic                enablen;
    logic [CODE_W-1:0]   key_code;
    logic                key_valid;
    logic                loadn;
    logic                multi_key;
    logic                p_tick;

    typedef struct {
        int cyc;
        int code;
    } kv_exp_t;

    kv_exp_t kv_q[$];
    int      tick_q[$];
    int      cyc      = 0;
    int      n_checks = 0;
    int      n_errors = 0;

    keypad_timebase #(
        .NUM_KEYS     (NUM_KEYS),
        .CODE_W       (CODE_W),
        .DEBOUNCE_CYC (4),
        .CLK_DIV      (5)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .keyboard  (keyboard),
        .enablen   (enablen),
        .key_code  (key_code),
        .key_valid (key_valid),
        .loadn     (loadn),
        .multi_key (multi_key),
        .p_tick    (p_tick)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // cyc = number of rising edges so far; outputs seen at a negedge
    // belong to the cycle after edge 'cyc'.
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check_val(input string tag, input logic [31:0] act, input logic [31:0] exp_v);
        n_checks++;
        if (act !== exp_v) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d", tag, act, exp_v);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge clk);
    endtask

    // Stable press from this cycle: first sample on the next edge, strobe
    // six cycles after that.
    task automatic press(input logic [NUM_KEYS-1:0] k, input int code);
        kv_exp_t e;
        e.cyc  = cyc + 7;
        e.code = code;
        kv_q.push_back(e);
        keyboard = k;
    endtask

    task automatic release_key(input string tag);
        keyboard = '0;
        step(4);
        check_val({tag, "_loadn_still_low"}, loadn, 0);
        for (int i = 0; i < 10; i++) begin
            if (loadn === 1'b1) break;
            step(1);
        end
        check_val({tag, "_loadn_released"}, loadn, 1);
    endtask

    // Scoreboard side: pop an expectation whenever the DUT strobes.
    always @(negedge clk) begin
        kv_exp_t e;
        int      t;
        if (key_valid === 1'b1) begin
            if (kv_q.size() == 0) begin
                check_val("kv_unexpected", 1, 0);
            end else begin
                e = kv_q.pop_front();
                check_val("kv_cycle", cyc, e.cyc);
                check_val("kv_code", key_code, e.code);
            end
        end
        if (p_tick === 1'b1) begin
            if (tick_q.size() == 0) begin
                check_val("tick_unexpected", 1, 0);
            end else begin
                t = tick_q.pop_front();
                check_val("tick_cycle", cyc, t);
            end
        end
    end

    initial begin
        int c;
        reset    = 1'b1;
        keyboard = '0;
        enablen  = 1'b1;
        step(3);
        check_val("rst_key_code", key_code, 0);
        check_val("rst_key_valid", key_valid, 0);
        check_val("rst_loadn", loadn, 1);
        check_val("rst_multi_key", multi_key, 0);
        check_val("rst_p_tick", p_tick, 0);
        reset = 1'b0;
        step(2);

        // 1: single clean key
        press(10'b00_0010_0000, 5);
        step(8);
        check_val("s1_loadn", loadn, 0);
        check_val("s1_multi", multi_key, 0);
        step(10);
        check_val("s1_loadn_held", loadn, 0);
        release_key("s1");
        check_val("s1_code_holds", key_code, 5);
        step(3);

        // 2: bounce on bit 3, runs of two, then held
        c = cyc;
        begin
            kv_exp_t e;
            e.cyc  = c + 15;
            e.code = 3;
            kv_q.push_back(e);
        end
        for (int i = 0; i < 10; i++) begin
            keyboard = (((i / 2) % 2) == 0) ? 10'b00_0000_1000 : 10'b0;
            step(1);
        end
        step(8);
        check_val("s2_loadn", loadn, 0);
        check_val("s2_code", key_code, 3);
        release_key("s2");
        step(3);

        // 3: two keys together
        press(10'b00_1000_0100, 2);
        step(8);
        check_val("s3_multi_held", multi_key, 1);
        check_val("s3_loadn", loadn, 0);
        release_key("s3");
        step(1);
        check_val("s3_multi_idle", multi_key, 0);
        step(3);

        // 4: release glitch while held
        press(10'b00_0001_0000, 4);
        step(9);
        keyboard = '0;
        step(2);
        keyboard = 10'b00_0001_0000;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check_val("s4_loadn_glitch", loadn, 0);
        end
        release_key("s4");
        step(3);

        // 5a: timer running, key ignored
        c = cyc;
        tick_q.push_back(c + 5);
        tick_q.push_back(c + 10);
        tick_q.push_back(c + 15);
        enablen = 1'b0;
        step(2);
        keyboard = 10'b00_0000_0010;
        step(10);
        check_val("s5_loadn_run", loadn, 1);
        check_val("s5_code_holds", key_code, 4);
        keyboard = '0;
        step(5);
        enablen = 1'b1;
        step(4);
        check_val("s5_tick_idle", p_tick, 0);

        // 5b: partial period discarded when enablen rises
        c = cyc;
        tick_q.push_back(c + 5);
        tick_q.push_back(c + 10);
        tick_q.push_back(c + 19);
        enablen = 1'b0;
        step(12);
        enablen = 1'b1;
        step(2);
        enablen = 1'b0;
        step(8);
        enablen = 1'b1;
        step(3);

        // 5c: enablen falls while a key is held
        press(10'b00_0100_0000, 6);
        step(9);
        check_val("s5c_loadn_held", loadn, 0);
        c = cyc;
        tick_q.push_back(c + 5);
        enablen = 1'b0;
        step(1);
        check_val("s5c_loadn_forced", loadn, 1);
        check_val("s5c_code_holds", key_code, 6);
        keyboard = '0;
        step(5);
        enablen = 1'b1;
        step(3);

        // 6a: reset during debounce
        keyboard = 10'b01_0000_0000;
        step(4);
        reset    = 1'b1;
        keyboard = '0;
        step(1);
        check_val("s6_code", key_code, 0);
        check_val("s6_valid", key_valid, 0);
        check_val("s6_loadn", loadn, 1);
        check_val("s6_multi", multi_key, 0);
        reset = 1'b0;
        step(10);

        // 6b: reset during divider count restarts the period
        c = cyc;
        enablen = 1'b0;
        step(3);
        reset = 1'b1;
        step(1);
        check_val("s6_tick", p_tick, 0);
        reset = 1'b0;
        tick_q.push_back(c + 9);
        step(6);
        enablen = 1'b1;
        step(4);

        check_val("kv_queue_empty", kv_q.size(), 0);
        check_val("tick_queue_empty", tick_q.size(), 0);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
`default_nettype wire
